// File: rtl/issue_queue_free_list_pkg.sv
// Shared scheduler types and sizing for the issue-queue free list.
package issue_queue_free_list_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM = 16;
  localparam int DISPATCH_WIDTH        = 2;
  localparam int ISSUE_WIDTH           = 2;
  localparam int ALLOC_WIDTH           = DISPATCH_WIDTH;
  localparam int RELEASE_WIDTH         = ISSUE_WIDTH;
  localparam int IDX_W                 = $clog2(ISSUE_QUEUE_ENTRY_NUM);

  typedef logic [IDX_W-1:0] IssueQueueIndexPath;
  typedef logic [IDX_W:0]   IssueQueueCountPath;

  // Tail pointer of a completely full list: same index as head, wrap bit set.
  function automatic IssueQueueCountPath fullTailPtr();
    return IssueQueueCountPath'(ISSUE_QUEUE_ENTRY_NUM);
  endfunction

endpackage

// File: rtl/issue_queue_free_list_if.sv
// Rename-side allocation and scheduler-side release signals of the free list.
interface issue_queue_free_list_if
  import issue_queue_free_list_pkg::*;
();

  logic [ALLOC_WIDTH-1:0]                     allocReq;
  IssueQueueIndexPath [ALLOC_WIDTH-1:0]       allocPtr;
  logic                                       allocatable;
  logic [RELEASE_WIDTH-1:0]                   releaseReq;
  IssueQueueIndexPath [RELEASE_WIDTH-1:0]     releasePtr;

  modport master (
    output allocReq, releaseReq, releasePtr,
    input  allocPtr, allocatable
  );

  modport slave (
    input  allocReq, releaseReq, releasePtr,
    output allocPtr, allocatable
  );

endinterface

// File: rtl/issue_queue_free_list_prefix_count.sv
// Per-lane exclusive popcount: prefix_o[k] counts set bits of req_i below lane k,
// prefix_o[WIDTH] is the total.
module issue_queue_free_list_prefix_count #(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            req_i,
  output logic [WIDTH:0][CNT_W-1:0]   prefix_o
);

  logic [CNT_W-1:0] acc;

  // Running sum across lanes, each lane sees the count of lanes before it.
  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      prefix_o[k] = acc;
      acc         = acc + CNT_W'(req_i[k]);
    end
    prefix_o[WIDTH] = acc;
  end

endmodule

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices with multi-lane grant/release.
module issue_queue_free_list
  import issue_queue_free_list_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  issue_queue_free_list_if.slave   port_io,
  output IssueQueueCountPath       freeCount_o,
  output logic                     overflowErr_o
);

  localparam int ALLOC_CNT_W = $clog2(ALLOC_WIDTH + 1);
  localparam int REL_CNT_W   = $clog2(RELEASE_WIDTH + 1);

  typedef logic [IDX_W+1:0] ProjectedPath;

  IssueQueueIndexPath freeList_q [ISSUE_QUEUE_ENTRY_NUM];
  IssueQueueCountPath headPtr_q, headPtr_d;
  IssueQueueCountPath tailPtr_q, tailPtr_d;
  IssueQueueCountPath count_q, count_d;
  logic               overflowErr_q, overflowErr_d;

  logic [ALLOC_WIDTH:0][ALLOC_CNT_W-1:0] allocPrefix;
  logic [RELEASE_WIDTH:0][REL_CNT_W-1:0] relPrefix;

  logic               allocatable;
  IssueQueueCountPath allocGrant;
  IssueQueueCountPath relTotal;
  ProjectedPath       projected;
  logic               overflowNow;
  IssueQueueIndexPath allocIdx;
  IssueQueueIndexPath relIdx [RELEASE_WIDTH];

  issue_queue_free_list_prefix_count #(.WIDTH(ALLOC_WIDTH)) u_allocPrefix (
    .req_i    (port_io.allocReq),
    .prefix_o (allocPrefix)
  );

  issue_queue_free_list_prefix_count #(.WIDTH(RELEASE_WIDTH)) u_relPrefix (
    .req_i    (port_io.releaseReq),
    .prefix_o (relPrefix)
  );

  assign allocatable         = (count_q >= IssueQueueCountPath'(ALLOC_WIDTH));
  assign port_io.allocatable = allocatable;
  assign freeCount_o         = count_q;
  assign overflowErr_o       = overflowErr_q;

  // Zero-latency grant: each lane reads the slot offset by requesting lanes below it.
  always_comb begin
    allocIdx         = '0;
    port_io.allocPtr = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      allocIdx            = headPtr_q[IDX_W-1:0] + IssueQueueIndexPath'(allocPrefix[k]);
      port_io.allocPtr[k] = freeList_q[allocIdx];
    end
  end

  // Next-state pointers, occupancy and overflow; an overflowing release is dropped whole.
  always_comb begin
    allocGrant    = allocatable ? IssueQueueCountPath'(allocPrefix[ALLOC_WIDTH]) : '0;
    relTotal      = IssueQueueCountPath'(relPrefix[RELEASE_WIDTH]);
    projected     = ProjectedPath'(count_q) + ProjectedPath'(relTotal) - ProjectedPath'(allocGrant);
    overflowNow   = (projected > ProjectedPath'(ISSUE_QUEUE_ENTRY_NUM));
    headPtr_d     = headPtr_q + allocGrant;
    tailPtr_d     = overflowNow ? tailPtr_q : (tailPtr_q + relTotal);
    count_d       = overflowNow ? (count_q - allocGrant) : projected[IDX_W:0];
    overflowErr_d = overflowErr_q | overflowNow;
    for (int j = 0; j < RELEASE_WIDTH; j++) begin
      relIdx[j] = tailPtr_q[IDX_W-1:0] + IssueQueueIndexPath'(relPrefix[j]);
    end
  end

  // State update; reset and flush both restore the identity image with a full list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ISSUE_QUEUE_ENTRY_NUM; i++) freeList_q[i] <= IssueQueueIndexPath'(i);
      headPtr_q     <= '0;
      tailPtr_q     <= fullTailPtr();
      count_q       <= IssueQueueCountPath'(ISSUE_QUEUE_ENTRY_NUM);
      overflowErr_q <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < ISSUE_QUEUE_ENTRY_NUM; i++) freeList_q[i] <= IssueQueueIndexPath'(i);
      headPtr_q     <= '0;
      tailPtr_q     <= fullTailPtr();
      count_q       <= IssueQueueCountPath'(ISSUE_QUEUE_ENTRY_NUM);
      overflowErr_q <= 1'b0;
    end else begin
      for (int j = 0; j < RELEASE_WIDTH; j++) begin
        if (port_io.releaseReq[j] && !overflowNow) freeList_q[relIdx[j]] <= port_io.releasePtr[j];
      end
      headPtr_q     <= headPtr_d;
      tailPtr_q     <= tailPtr_d;
      count_q       <= count_d;
      overflowErr_q <= overflowErr_d;
    end
  end

  // Rename must stall rather than request while fewer than ALLOC_WIDTH entries are free.
  noAllocWhenBlocked: assert property (@(posedge clk) disable iff (!rst_n)
    !(!flush_i && (|port_io.allocReq) && !allocatable));

endmodule
